pkt_rx_checker: RTL and testbench

//  Receive-side consumer of the packetised ADC stream (ADC_DATA/ADC_DATA_VALID).

---
 rtl/pkt_chk_pkg.sv | 29 ++
 rtl/pkt_pattern_gen.sv | 31 +++
 rtl/pkt_rx_checker.sv | 213 +++++++++++++++++++++
 tb/tb_pkt_rx_checker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_chk_pkg.sv
// Shared types and constants for the receive-side packet checker.
package pkt_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HUNT  = 3'd1,
    ST_PAYLD = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } chk_state_e;

  localparam logic [17:0] HDR_WORD_DEF = 18'h2A5A5;

  // Bit positions inside chk_err_flags
  localparam int ERR_DATA = 0;
  localparam int ERR_LEN  = 1;
  localparam int ERR_GAP  = 2;
  localparam int ERR_TO   = 3;

  function automatic logic [11:0] pkt_len_words(input logic [1:0] sel);
    case (sel)
      2'd0:    return 12'd256;
      2'd1:    return 12'd512;
      2'd2:    return 12'd1024;
      default: return 12'd2048;
    endcase
  endfunction

endpackage

// File: rtl/pkt_pattern_gen.sv
// Counter-pattern reference: word k of a payload is {c+1, c} with c = 2k (9-bit wrap).
module pkt_pattern_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        adv,
  output logic [17:0] exp_word
);

  logic [8:0] c_q, c_d;

  always_comb begin
    c_d = c_q;
    if (clr) begin
      c_d = 9'd0;
    end else if (adv) begin
      c_d = c_q + 9'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= 9'd0;
    end else begin
      c_q <= c_d;
    end
  end

  assign exp_word = {c_q + 9'd1, c_q};

endmodule

// File: rtl/pkt_rx_checker.sv
// Frames packets from the ADC stream and checks header, length, idle gap and
// (optionally) the counter payload pattern; results are reported to the register file.
module pkt_rx_checker
  import pkt_chk_pkg::*;
#(
  parameter int                DATA_W   = 18,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] HDR_WORD = DATA_W'(HDR_WORD_DEF),
  parameter logic [15:0]       TO_CYC   = 16'hFFFF
) (
  input  logic              pktctrl_clk,
  input  logic              pktctrl_rstn,
  input  logic              rf_chk_en,
  input  logic              rf_chk_pattern_en,
  input  logic [CNT_W-1:0]  rf_chk_pkt_num,
  input  logic [1:0]        rf_pkt_data_length,
  input  logic [15:0]       rf_pkt_idle_length,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic              ADC_DATA_VALID,
  output logic              DATA_RD_EN,
  output logic              chk_busy,
  output logic              chk_done,
  output logic [CNT_W-1:0]  chk_pkt_cnt,
  output logic [CNT_W-1:0]  chk_err_cnt,
  output logic [3:0]        chk_err_flags,
  output logic [DATA_W-1:0] chk_first_err_word
);

  chk_state_e        state_q, state_d;
  logic              en_q, rd_en_q, rd_en_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic [3:0]        flags_q, flags_d;
  logic [DATA_W-1:0] first_err_q, first_err_d;
  logic              first_seen_q, first_seen_d, pkt_err_q, pkt_err_d;
  logic [11:0]       len_q, len_d, wcnt_q, wcnt_d;
  logic [15:0]       idle_len_q, idle_len_d, idle_cnt_q, idle_cnt_d, to_cnt_q, to_cnt_d;
  logic              busy, in_rx, hdr_hit, data_mis, to_hit, last_pkt, pkt_done;
  logic              pat_clr, pat_adv;
  logic [17:0]       exp_word;

  pkt_pattern_gen u_pat (
    .clk      (pktctrl_clk),
    .rst_n    (pktctrl_rstn),
    .clr      (pat_clr),
    .adv      (pat_adv),
    .exp_word (exp_word)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_rx    = (state_q == ST_HUNT) || (state_q == ST_PAYLD);
  assign busy     = in_rx || (state_q == ST_GAP);
  assign hdr_hit  = ADC_DATA_VALID && (ADC_DATA == HDR_WORD);
  assign data_mis = rf_chk_pattern_en && (ADC_DATA != DATA_W'(exp_word));
  assign to_hit   = !ADC_DATA_VALID && (to_cnt_q == TO_CYC - 16'd1);
  assign last_pkt = (rf_chk_pkt_num != '0) && (pkt_cnt_q == rf_chk_pkt_num);

  always_comb begin
    state_d      = state_q;
    pkt_cnt_d    = pkt_cnt_q;
    err_cnt_d    = err_cnt_q;
    flags_d      = flags_q;
    first_err_d  = first_err_q;
    first_seen_d = first_seen_q;
    pkt_err_d    = pkt_err_q;
    len_d        = len_q;
    idle_len_d   = idle_len_q;
    wcnt_d       = wcnt_q;
    idle_cnt_d   = idle_cnt_q;
    pat_clr      = 1'b0;
    pat_adv      = 1'b0;
    pkt_done     = 1'b0;
    rd_en_d      = busy;
    to_cnt_d     = (in_rx && !ADC_DATA_VALID) ? to_cnt_q + 16'd1 : 16'd0;

    case (state_q)
      ST_IDLE: begin
        if (rf_chk_en && !en_q) begin
          state_d      = ST_HUNT;
          pkt_cnt_d    = '0;
          err_cnt_d    = '0;
          flags_d      = '0;
          first_err_d  = '0;
          first_seen_d = 1'b0;
          pkt_err_d    = 1'b0;
          len_d        = pkt_len_words(rf_pkt_data_length);
          idle_len_d   = rf_pkt_idle_length;
        end
      end
      ST_HUNT: begin
        if (!rf_chk_en) begin
          state_d = ST_IDLE;
        end else if (to_hit) begin
          flags_d[ERR_TO] = 1'b1;
          state_d         = ST_DONE;
        end else if (hdr_hit) begin
          state_d = ST_PAYLD;
          wcnt_d  = '0;
          pat_clr = 1'b1;
        end
      end
      ST_PAYLD: begin
        if (!rf_chk_en) begin
          state_d = ST_IDLE;
        end else if (to_hit) begin
          flags_d[ERR_TO] = 1'b1;
          state_d         = ST_DONE;
        end else if (!ADC_DATA_VALID) begin
          // Short packet: still framed, but counted as bad
          flags_d[ERR_LEN] = 1'b1;
          pkt_err_d        = 1'b1;
          pkt_done         = 1'b1;
          idle_cnt_d       = '0;
          state_d          = ST_GAP;
        end else begin
          pat_adv = 1'b1;
          if (data_mis) begin
            flags_d[ERR_DATA] = 1'b1;
            pkt_err_d         = 1'b1;
            if (!first_seen_q) begin
              first_err_d  = ADC_DATA;
              first_seen_d = 1'b1;
            end
          end
          if (wcnt_q == len_q - 12'd1) begin
            pkt_done   = 1'b1;
            idle_cnt_d = '0;
            state_d    = ST_GAP;
          end else begin
            wcnt_d = wcnt_q + 12'd1;
          end
        end
      end
      ST_GAP: begin
        if (!rf_chk_en) begin
          state_d = ST_IDLE;
        end else if (ADC_DATA_VALID) begin
          // An early word is charged to the packet it may start
          if (idle_cnt_q < idle_len_q) begin
            flags_d[ERR_GAP] = 1'b1;
            pkt_err_d        = 1'b1;
          end
          if (hdr_hit) begin
            state_d = ST_PAYLD;
            wcnt_d  = '0;
            pat_clr = 1'b1;
          end else begin
            state_d = ST_HUNT;
          end
        end else if (({1'b0, idle_cnt_q} + 17'd1) >= {1'b0, idle_len_q}) begin
          state_d = last_pkt ? ST_DONE : ST_HUNT;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (pkt_done) begin
      pkt_cnt_d = sat_inc(pkt_cnt_q);
      if (pkt_err_d) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end
      pkt_err_d = 1'b0;
    end
  end

  always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
    if (!pktctrl_rstn) begin
      state_q      <= ST_IDLE;
      en_q         <= 1'b0;
      rd_en_q      <= 1'b0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
      flags_q      <= '0;
      first_err_q  <= '0;
      first_seen_q <= 1'b0;
      pkt_err_q    <= 1'b0;
      len_q        <= '0;
      idle_len_q   <= '0;
      wcnt_q       <= '0;
      idle_cnt_q   <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= rf_chk_en;
      rd_en_q      <= rd_en_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
      flags_q      <= flags_d;
      first_err_q  <= first_err_d;
      first_seen_q <= first_seen_d;
      pkt_err_q    <= pkt_err_d;
      len_q        <= len_d;
      idle_len_q   <= idle_len_d;
      wcnt_q       <= wcnt_d;
      idle_cnt_q   <= idle_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign DATA_RD_EN         = rd_en_q;
  assign chk_busy           = busy;
  assign chk_done           = (state_q == ST_DONE);
  assign chk_pkt_cnt        = pkt_cnt_q;
  assign chk_err_cnt        = err_cnt_q;
  assign chk_err_flags      = flags_q;
  assign chk_first_err_word = first_err_q;

endmodule

// File: tb/tb_pkt_rx_checker.sv
// Randomized bench for pkt_rx_checker with a packet-level reference model.
module tb_pkt_rx_checker;

  localparam int          DATA_W = 18;
  localparam int          CNT_W  = 4;
  localparam int          CMAX   = (1 << CNT_W) - 1;
  localparam logic [15:0] TO_CYC = 16'd1000;
  localparam logic [17:0] HDR    = 18'h2A5A5;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              en, pen, valid;
  logic [CNT_W-1:0]  pkt_num;
  logic [1:0]        len_sel;
  logic [15:0]       idle_len;
  logic [DATA_W-1:0] data;
  logic              rd_en, busy, done;
  logic [CNT_W-1:0]  pkt_cnt, err_cnt;
  logic [3:0]        flags;
  logic [DATA_W-1:0] first_err;

  pkt_rx_checker #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .HDR_WORD (HDR),
    .TO_CYC (TO_CYC)
  ) dut (
    .pktctrl_clk        (clk),
    .pktctrl_rstn       (rstn),
    .rf_chk_en          (en),
    .rf_chk_pattern_en  (pen),
    .rf_chk_pkt_num     (pkt_num),
    .rf_pkt_data_length (len_sel),
    .rf_pkt_idle_length (idle_len),
    .ADC_DATA           (data),
    .ADC_DATA_VALID     (valid),
    .DATA_RD_EN         (rd_en),
    .chk_busy           (busy),
    .chk_done           (done),
    .chk_pkt_cnt        (pkt_cnt),
    .chk_err_cnt        (err_cnt),
    .chk_err_flags      (flags),
    .chk_first_err_word (first_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Done-pulse monitor, sampled shortly after each rising edge
  int done_cnt = 0, done_run = 0, done_run_max = 0;
  always @(posedge clk) begin
    #2;
    if (done === 1'b1) begin
      done_cnt++;
      done_run++;
      if (done_run > done_run_max) done_run_max = done_run;
    end else begin
      done_run = 0;
    end
  end

  // Packet-level reference model state
  int          exp_pkt, exp_err, prev_gap, cfg_idle;
  bit          first_pkt, first_set, cfg_pen;
  logic [3:0]  exp_flags;
  logic [17:0] exp_first;

  function automatic logic [17:0] pat_word(input int k);
    logic [8:0] c;
    c = 9'((2 * k) % 512);
    return {9'((c + 1) % 512), c};
  endfunction

  task automatic start_run(input logic [1:0] lsel, input int idl, input int num, input bit p_en);
    @(negedge clk);
    en = 1'b0; valid = 1'b0;
    len_sel = lsel; idle_len = 16'(idl); pkt_num = CNT_W'(num); pen = p_en;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_pkt = 0; exp_err = 0; exp_flags = 4'b0; exp_first = '0;
    first_set = 1'b0; first_pkt = 1'b1; prev_gap = 0;
    cfg_idle = idl; cfg_pen = p_en;
  endtask

  task automatic send_pkt(input int len, input int sent, input int bad_idx,
                          input logic [17:0] bad_val, input int idle_after);
    bit trunc, gap, dbad;
    trunc = (sent < len);
    gap   = !first_pkt && (prev_gap < cfg_idle);
    dbad  = cfg_pen && (bad_idx >= 0) && (bad_idx < sent);
    if (dbad) begin
      exp_flags[0] = 1'b1;
      if (!first_set) begin
        exp_first = bad_val;
        first_set = 1'b1;
      end
    end
    if (trunc) exp_flags[1] = 1'b1;
    if (gap)   exp_flags[2] = 1'b1;
    if (exp_pkt < CMAX) exp_pkt++;
    if ((trunc || gap || dbad) && exp_err < CMAX) exp_err++;
    prev_gap  = trunc ? idle_after - 1 : idle_after;
    first_pkt = 1'b0;
    @(negedge clk);
    valid = 1'b1; data = HDR;
    for (int k = 0; k < sent; k++) begin
      @(negedge clk);
      data = (k == bad_idx) ? bad_val : pat_word(k);
    end
    for (int k = 0; k < idle_after; k++) begin
      @(negedge clk);
      valid = 1'b0; data = 18'($urandom);
    end
  endtask

  task automatic wait_done(input int budget, input int base, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done_cnt != base) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic check_run(input string tag);
    check_val({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
    check_val({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    check_val({tag, "_flags"}, 32'(flags), 32'(exp_flags));
    check_val({tag, "_first_err"}, 32'(first_err), 32'(exp_first));
  endtask

  task automatic finish_run(input string tag, input int budget);
    int base, cyc;
    base = done_cnt;
    wait_done(budget, base, cyc);
    check_val({tag, "_done_seen"}, 32'(cyc > 0), 32'd1);
    check_run(tag);
    @(negedge clk);
    check_val({tag, "_rd_en_off"}, 32'(rd_en), 32'd0);
    check_val({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cyc;
    en = 1'b0; pen = 1'b1; valid = 1'b0; pkt_num = '0; len_sel = 2'd0;
    idle_len = 16'd16; data = '0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_outs", {26'd0, rd_en, busy, done, 3'd0},
              32'd0);
    check_val("rst_cnts", {pkt_cnt, err_cnt, flags}, 32'd0);
    check_val("rst_first", 32'(first_err), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Four clean 256-word packets
    start_run(2'd0, 16, 4, 1'b1);
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_rd_en", 32'(rd_en), 32'd1);
    for (int p = 0; p < 4; p++) send_pkt(256, 256, -1, '0, (p == 3) ? 1 : 20);
    finish_run("t1", 60);

    // Zero word at payload index 5 of the second packet
    start_run(2'd0, 16, 3, 1'b1);
    send_pkt(256, 256, -1, '0, 20);
    send_pkt(256, 256, 5, 18'h00000, 20);
    send_pkt(256, 256, -1, '0, 1);
    finish_run("t2", 60);

    // Packet cut short after 100 words, then a good one
    start_run(2'd0, 16, 2, 1'b1);
    send_pkt(256, 100, -1, '0, 22);
    send_pkt(256, 256, -1, '0, 1);
    finish_run("t3", 60);

    // Next header only 3 idle cycles after a packet
    start_run(2'd0, 16, 2, 1'b1);
    send_pkt(256, 256, -1, '0, 3);
    send_pkt(256, 256, -1, '0, 1);
    finish_run("t4", 60);

    // No traffic at all: timeout
    @(negedge clk);
    en = 1'b0; valid = 1'b0; pkt_num = '0;
    @(negedge clk);
    en = 1'b1;
    base = done_cnt;
    wait_done(int'(TO_CYC) + 50, base, cyc);
    check_val("t5_to_latency", 32'(cyc), 32'(int'(TO_CYC) + 1));
    check_val("t5_flags", 32'(flags), 32'h8);
    check_val("t5_pkt_cnt", 32'(pkt_cnt), 32'd0);
    @(negedge clk);
    check_val("t5_rd_en_off", 32'(rd_en), 32'd0);

    // Abort in the middle of a payload, then restart
    start_run(2'd0, 16, 0, 1'b1);
    send_pkt(256, 256, -1, '0, 20);
    @(negedge clk);
    valid = 1'b1; data = HDR;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      data = pat_word(k);
    end
    @(negedge clk);
    en = 1'b0; valid = 1'b0;
    base = done_cnt;
    repeat (20) @(negedge clk);
    check_val("t6_no_done", 32'(done_cnt - base), 32'd0);
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_rd_en", 32'(rd_en), 32'd0);
    check_run("t6_held");
    en = 1'b1;
    repeat (2) @(negedge clk);
    check_val("t6_cleared", {pkt_cnt, err_cnt, flags}, 32'd0);
    check_val("t6_rebusy", 32'(busy), 32'd1);

    // Counter saturation: 17 bad packets in continuous mode
    start_run(2'd0, 4, 0, 1'b1);
    for (int p = 0; p < 17; p++) begin
      int bi;
      bi = $urandom_range(0, 255);
      send_pkt(256, 256, bi, pat_word(bi) ^ 18'($urandom_range(1, 262143)), 6);
    end
    check_run("sat");
    @(negedge clk);
    en = 1'b0;

    // Randomized runs
    for (int it = 0; it < 3; it++) begin
      int lsel, idl, np, ln;
      bit   p_en;
      lsel = $urandom_range(0, 3);
      idl  = $urandom_range(4, 30);
      np   = $urandom_range(2, 4);
      p_en = ($urandom_range(0, 3) != 0);
      ln   = 256 << lsel;
      start_run(2'(lsel), idl, np, p_en);
      for (int p = 0; p < np; p++) begin
        int sent, bidx, ia;
        logic [17:0] bv;
        sent = ln; bidx = -1; bv = '0;
        if ($urandom_range(0, 5) == 0) sent = $urandom_range(1, ln - 1);
        if ($urandom_range(0, 2) == 0) begin
          bidx = $urandom_range(0, ln - 1);
          bv   = pat_word(bidx) ^ 18'($urandom_range(1, 262143));
        end
        if (p == np - 1) ia = 1;
        else if (sent == ln && $urandom_range(0, 3) == 0) ia = $urandom_range(1, idl - 2);
        else ia = $urandom_range(idl + 2, idl + 8);
        send_pkt(ln, sent, bidx, bv, ia);
      end
      finish_run($sformatf("rnd%0d", it), idl + 40);
    end

    check_val("done_width", 32'(done_run_max), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
